// File: rtl/mpsoc_wb_uart_receiver_if.sv
// RX FIFO access bundle between the UART receiver and the register block.
// The master is the register block: it pops entries and issues clears.
// The slave is the receiver: it returns the head entry, the fill level and the status flags.
interface mpsoc_wb_uart_receiver_if #(
    parameter int FIFO_COUNTER_W = 5
);
    logic                      rf_pop;
    logic                      rx_reset;
    logic                      lsr_mask;
    logic [10:0]               rf_data_out;
    logic [FIFO_COUNTER_W-1:0] rf_count;
    logic                      rf_overrun;
    logic                      rf_error;

    modport master (
        output rf_pop, rx_reset, lsr_mask,
        input  rf_data_out, rf_count, rf_overrun, rf_error
    );

    modport slave (
        input  rf_pop, rx_reset, lsr_mask,
        output rf_data_out, rf_count, rf_overrun, rf_error
    );
endinterface

// File: rtl/mpsoc_wb_uart_receiver.sv
// Receive half of the Wishbone UART.
// Samples the serial line on a 16x baud tick and deserialises 5-8 bit characters.
// Each character is checked for parity, framing and break.
// The character and its error tags go into a 16-entry RX FIFO.
//
// state          | meaning
// r_idle       0 | line idle, waiting for a falling edge
// r_rec_start  1 | counting to the middle of the start bit
// r_rec_bit    2 | sampling data bits, LSB first
// r_rec_parity 3 | sampling the parity bit
// r_rec_stop   4 | sampling the first stop bit
// r_push       5 | writing {BI,FE,PE,data} into the FIFO
// r_wait_idle  6 | after a framing error, waiting for the line to return high
module mpsoc_wb_uart_receiver #(
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_POINTER_W = 4,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                         clk,
    input  logic                         wb_rst_ni,
    input  logic [7:0]                   lcr,
    input  logic                         srx_pad_i,
    input  logic                         enable,
    mpsoc_wb_uart_receiver_if.slave      rf,
    output logic [2:0]                   rstate
);

    typedef enum logic [2:0] {
        r_idle       = 3'd0,
        r_rec_start  = 3'd1,
        r_rec_bit    = 3'd2,
        r_rec_parity = 3'd3,
        r_rec_stop   = 3'd4,
        r_push       = 3'd5,
        r_wait_idle  = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic       rx_meta, rxd;
    logic [3:0] cnt;
    logic [2:0] bit_idx, last_idx;
    logic [7:0] data;
    logic       par_bit, pe, fe;
    logic       par_exp, bi, sample, push;
    logic [10:0] push_word;

    // lcr[7:6] belong to the divisor-latch/break controls of the other half
    logic lcr_unused;
    assign lcr_unused = &{1'b0, lcr[7:6]};

    assign sample    = enable && (cnt == 4'd0);
    assign push      = enable && (state_q == r_push);
    // break: all-zero character, missing stop bit, and parity bit low if there is one
    assign bi        = (data == 8'd0) && fe && !par_bit;
    assign push_word = {bi, fe, pe, data};
    assign rstate    = state_q;

    // expected parity by {EP, stick}
    always_comb begin
        par_exp = 1'b0;
        case ({lcr[4], lcr[5]})
            2'b00:   par_exp = ~^data;
            2'b10:   par_exp = ^data;
            2'b01:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    // two-flop synchroniser on the serial input, idles high
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_meta <= 1'b1;
            rxd     <= 1'b1;
        end else begin
            rx_meta <= srx_pad_i;
            rxd     <= rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= r_idle;
        else            state_q <= state_d;
    end

    // FSM next-state logic, advancing only on baud ticks
    always_comb begin
        state_d = state_q;
        case (state_q)
            r_idle:       if (enable && !rxd) state_d = r_rec_start;
            r_rec_start:  if (sample) state_d = rxd ? r_idle : r_rec_bit;
            r_rec_bit:    if (sample && (bit_idx == last_idx))
                              state_d = lcr[3] ? r_rec_parity : r_rec_stop;
            r_rec_parity: if (sample) state_d = r_rec_stop;
            r_rec_stop:   if (sample) state_d = r_push;
            r_push:       if (enable) state_d = fe ? r_wait_idle : r_idle;
            r_wait_idle:  if (enable && rxd) state_d = r_idle;
            default:      state_d = r_idle;
        endcase
    end

    // sample counter, bit counter and captured frame fields
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt      <= 4'd0;
            bit_idx  <= 3'd0;
            last_idx <= 3'd0;
            data     <= 8'd0;
            par_bit  <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
        end else if (enable) begin
            case (state_q)
                r_idle: if (!rxd) cnt <= 4'd7;
                r_rec_start: begin
                    if (cnt == 4'd0) begin
                        // word length is frozen here for the whole frame
                        cnt      <= 4'd15;
                        bit_idx  <= 3'd0;
                        last_idx <= 3'd4 + {1'b0, lcr[1:0]};
                        data     <= 8'd0;
                        par_bit  <= 1'b0;
                        pe       <= 1'b0;
                        fe       <= 1'b0;
                    end else cnt <= cnt - 4'd1;
                end
                r_rec_bit: begin
                    if (cnt == 4'd0) begin
                        cnt           <= 4'd15;
                        data[bit_idx] <= rxd;
                        bit_idx       <= bit_idx + 3'd1;
                    end else cnt <= cnt - 4'd1;
                end
                r_rec_parity: begin
                    if (cnt == 4'd0) begin
                        cnt     <= 4'd15;
                        par_bit <= rxd;
                        pe      <= (rxd != par_exp);
                    end else cnt <= cnt - 4'd1;
                end
                r_rec_stop: begin
                    if (cnt == 4'd0) begin
                        cnt <= 4'd15;
                        fe  <= ~rxd;
                    end else cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [10:0]               mem [FIFO_DEPTH];
    logic [FIFO_POINTER_W-1:0] wp, rp;
    logic [FIFO_COUNTER_W-1:0] count, err_cnt;
    logic                      overrun, full, pop_ok, push_ok, push_err, head_err;
    logic [10:0]               head;

    assign full     = (count == FIFO_COUNTER_W'(FIFO_DEPTH));
    assign pop_ok   = rf.rf_pop && (count != '0);
    assign push_ok  = push && !rf.rx_reset && (!full || pop_ok);
    assign head     = mem[rp];
    assign push_err = |push_word[10:8];
    assign head_err = |head[10:8];

    // an empty FIFO presents zero rather than a stale slot
    assign rf.rf_data_out = (count == '0) ? 11'd0 : head;
    assign rf.rf_count    = count;
    assign rf.rf_overrun  = overrun;
    assign rf.rf_error    = (err_cnt != '0);

    // storage array, written at the tail
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= push_word;
    end

    // pointers, fill level, error count and overrun flag
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            err_cnt <= '0;
            overrun <= 1'b0;
        end else if (rf.rx_reset) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            err_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + FIFO_POINTER_W'(1);
            if (pop_ok)  rp <= rp + FIFO_POINTER_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + FIFO_COUNTER_W'(1);
                2'b01:   count <= count - FIFO_COUNTER_W'(1);
                default: ;
            endcase
            case ({push_ok && push_err, pop_ok && head_err})
                2'b10:   err_cnt <= err_cnt + FIFO_COUNTER_W'(1);
                2'b01:   err_cnt <= err_cnt - FIFO_COUNTER_W'(1);
                default: ;
            endcase
            // a new overrun takes priority over the clear from the LSR read
            if (push && full && !pop_ok) overrun <= 1'b1;
            else if (rf.lsr_mask)        overrun <= 1'b0;
        end
    end

endmodule

// File: doc/mpsoc_wb_uart_receiver.md
Name: mpsoc_wb_uart_receiver

Overview:
Receive half of the Wishbone UART core. It samples the serial input on a 16x baud enable and deserialises 5-8 bit characters using the shared LCR framing. It checks parity and stop bit, detects break, and pushes each character with its error tags into an internal 16-entry RX FIFO read by the register block.

Parameters:
FIFO_DEPTH, 16, RX FIFO entries
FIFO_POINTER_W, 4, log2(FIFO_DEPTH)
FIFO_COUNTER_W, 5, width of rf_count (holds 0..FIFO_DEPTH)

Ports:
clk  in  1  core clock
wb_rst_ni  in  1  reset, asynchronous, active-low
lcr  in  8  [1:0] word length 5..8, [2] stop bits, [3] PE, [4] EP, [5] stick parity; [7:6] ignored
srx_pad_i  in  1  serial input, idle high
enable  in  1  16x baud tick, one clk wide
rf_pop  in  1  pop head entry, one clk wide
rx_reset  in  1  synchronous FIFO clear
lsr_mask  in  1  clears rf_overrun
rf_data_out  out  11  head entry {BI,FE,PE,data[7:0]}, combinational from head
rf_count  out  FIFO_COUNTER_W  entries held
rf_overrun  out  1  sticky: push attempted while full
rf_error  out  1  at least one held entry has PE|FE|BI set
rstate  out  3  FSM state, for status and debug

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset wb_rst_ni is asynchronous, active-low.
  - Reset values: rstate=r_idle(0), rf_count=0, rf_overrun=0, rf_error=0, rf_data_out=0.
  - Reset also clears the counters and shift register, and sets the 2-flop input synchroniser to 1.
- Sampling:
  - srx_pad_i passes through the 2-flop synchroniser; rxd is the synchronised value.
  - The FSM advances only on clk edges where enable=1.
  - The 4-bit sample counter decrements once per enable tick. A bit is sampled when the counter reaches 0, then the counter reloads to 15, so each bit takes 16 ticks.
- FSM states and transitions:
  - r_idle(0): if rxd=0, load counter=7 and go to r_rec_start.
  - r_rec_start(1): at counter 0, if rxd=1 it is a false start and the FSM returns to r_idle with no push. Otherwise load bit count = 5+lcr[1:0] and go to r_rec_bit.
  - r_rec_bit(2): at each sample, shift rxd in LSB-first; the final character is right-justified and unused upper bits are 0. After the last bit, go to r_rec_parity if lcr[3]=1, else to r_rec_stop.
  - r_rec_parity(3): sample the parity bit. Expected value by {EP,SP}: 00 = ~^data (odd), 10 = ^data (even), 01 = 1, 11 = 0. PE = (sample != expected).
  - r_rec_stop(4): sample the first stop bit only. FE = (rxd=0). Then go to r_push.
  - r_push(5): push {BI,FE,PE,data} for one tick.
    - BI = (data==0) & FE & (parity sample==0 or PE disabled).
    - Next state is r_wait_idle if FE=1, else r_idle.
  - r_wait_idle(6): stay until rxd=1 (sampled on an enable tick), then go to r_idle. This prevents a break from retriggering a start.
  - Illegal rstate value: go to r_idle.
- lcr is sampled live. The word length is latched at the r_rec_start sample; a change mid-frame takes effect on the next frame.
- RX FIFO:
  - Circular buffer with write/read pointers and a count.
  - Pop with rf_count=0 is ignored.
  - Push while full, without a simultaneous pop: data is dropped, the stored contents are unchanged, and rf_overrun is set.
  - Simultaneous push and pop:
    - When full: both are performed, count is unchanged, no overrun.
    - When empty: only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Error tracking:
  - An error counter increments on a push of an entry with any tag set, and decrements on a pop of such an entry.
  - rf_error = (error counter != 0).
- Clear controls:
  - rx_reset=1 on the next clk edge clears the pointers, rf_count, the error counter and rf_overrun. The FSM is unaffected.
  - A push in the same cycle as rx_reset is discarded.
  - lsr_mask=1 clears rf_overrun only. If an overrun occurs in that same cycle, the set wins.
- Latency: the entry becomes visible (rf_count increments) on the enable tick after the stop-bit sample. With enable=1 every cycle, a full frame is at most (1+bits+PE+1)*16 ticks.

Test Plan:
- enable=1 every clk, lcr=8'h03, send 0xA5 8N1 -> after ~160 ticks rf_count=1, rf_data_out=11'h0A5; rf_pop -> rf_count=0.
- lcr=8'h1B (8E1), send 0x07 with parity bit 0 -> entry 11'h107 (PE), rf_error=1; pop -> rf_error=0.
- Low glitch of 4 ticks on an idle line -> rstate returns to 0, rf_count stays 0.
- Hold srx_pad_i low for 3 frames, lcr=8'h03 -> one entry 11'h600 (BI|FE); rstate=6 until the line rises, then 0.
- Send 17 chars without popping -> rf_count=16, rf_overrun=1, head=first char; lsr_mask pulse -> rf_overrun=0.
- FIFO full with rf_pop coinciding with a push -> rf_count stays 16, rf_overrun=0. Drive wb_rst_ni low mid-frame -> all outputs at reset values immediately.
